// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the responder, the arbiter and the masters.
package axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_RD_WAIT,
    RSP_RD_RESP,
    RSP_WR_WAIT,
    RSP_WR_RESP
  } axil_rsp_state_t;

endpackage

// File: rtl/axil_sram_store.sv
// Word-addressed 32-bit SRAM with a registered read port and a 4-lane byte-masked write port.
module axil_sram_store #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axil_sram_responder.sv
// AXI4-Lite responder over a local SRAM: one transaction at a time, fixed per-direction latency.
module axil_sram_responder
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 2,
  parameter int          WRITE_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_awvalid,
  input  logic [31:0] mem_awaddr,
  output logic        mem_awready,
  input  logic        mem_wvalid,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_wstrb,
  output logic        mem_wready,
  output logic        mem_bvalid,
  output logic [1:0]  mem_bresp,
  input  logic        mem_bready,
  input  logic        mem_arvalid,
  input  logic [31:0] mem_araddr,
  output logic        mem_arready,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic [1:0]  mem_rresp,
  input  logic        mem_rready
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN        = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  RD_CNT_INIT = 4'(READ_LAT - 1);
  localparam logic [3:0]  WR_CNT_INIT = 4'(WRITE_LAT - 1);

  axil_rsp_state_t state;
  logic [3:0]      cnt;
  logic            rdy_q;
  logic            rd_ok_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;

  logic [31:0]     off;
  logic            in_range;
  logic [AW-1:0]   word_idx;
  logic            rd_fire;
  logic            wr_fire;
  logic [31:0]     store_rdata;
  logic            unused_wstrb_hi;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fall out of range.
  assign off             = addr_q - BASE_ADDR;
  assign in_range        = off < SPAN;
  assign word_idx        = off[AW+1:2];
  assign rd_fire         = (state == RSP_RD_WAIT) && (cnt == 4'd0);
  assign wr_fire         = (state == RSP_WR_WAIT) && (cnt == 4'd0) && in_range;
  assign unused_wstrb_hi = ^mem_wstrb[7:4];

  assign mem_arready = rdy_q;
  assign mem_awready = rdy_q;
  assign mem_wready  = rdy_q;
  // Out-of-range reads return zero; the store output itself only changes on a read fire.
  assign mem_rdata   = rd_ok_q ? store_rdata : 32'h0;

  axil_sram_store #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_store (
    .clk     (clk),
    .rd_en   (rd_fire),
    .rd_addr (word_idx),
    .rd_data (store_rdata),
    .wr_en   (wr_fire),
    .wr_addr (word_idx),
    .wr_data (wdata_q),
    .wr_strb (wstrb_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RSP_IDLE;
      cnt        <= 4'd0;
      rdy_q      <= 1'b0;
      rd_ok_q    <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_bvalid <= 1'b0;
      mem_rresp  <= AXI_RESP_OKAY;
      mem_bresp  <= AXI_RESP_OKAY;
    end else begin
      case (state)
        RSP_IDLE: begin
          rdy_q <= 1'b1;
          // Read has priority; a pending write keeps its valids up until the next IDLE.
          if (rdy_q && mem_arvalid) begin
            addr_q <= mem_araddr;
            cnt    <= RD_CNT_INIT;
            rdy_q  <= 1'b0;
            state  <= RSP_RD_WAIT;
          end else if (rdy_q && mem_awvalid && mem_wvalid) begin
            addr_q  <= mem_awaddr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb[3:0];
            cnt     <= WR_CNT_INIT;
            rdy_q   <= 1'b0;
            state   <= RSP_WR_WAIT;
          end
        end
        RSP_RD_WAIT: begin
          if (cnt == 4'd0) begin
            mem_rvalid <= 1'b1;
            mem_rresp  <= in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            rd_ok_q    <= in_range;
            state      <= RSP_RD_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RSP_RD_RESP: begin
          if (mem_rready) begin
            mem_rvalid <= 1'b0;
            rdy_q      <= 1'b1;
            state      <= RSP_IDLE;
          end
        end
        RSP_WR_WAIT: begin
          if (cnt == 4'd0) begin
            mem_bvalid <= 1'b1;
            mem_bresp  <= in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            state      <= RSP_WR_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RSP_WR_RESP: begin
          if (mem_bready) begin
            mem_bvalid <= 1'b0;
            rdy_q      <= 1'b1;
            state      <= RSP_IDLE;
          end
        end
        default: begin
          state <= RSP_IDLE;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_sram_responder.sv
// Scoreboard bench for axil_sram_responder: expectations queued at issue, checked at R/B handshakes.
`timescale 1ns/1ps
module tb_axil_sram_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DW   = 1024;
  localparam int          RL   = 2;
  localparam int          WL   = 2;

  logic        clk, rst;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready;
  logic [31:0] mem_awaddr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid, mem_bready;
  logic [1:0]  mem_bresp;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [1:0]  mem_rresp;

  axil_sram_responder #(
    .BASE_ADDR(BASE), .DEPTH_WORDS(DW), .READ_LAT(RL), .WRITE_LAT(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr), .mem_awready(mem_awready),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wready(mem_wready),
    .mem_bvalid(mem_bvalid), .mem_bresp(mem_bresp), .mem_bready(mem_bready),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rready(mem_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_rhs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DW * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[31:2]);
  endfunction

  function automatic exp_t exp_rd(input logic [31:0] a);
    exp_t e;
    e.is_rd = 1'b1;
    if (in_rng(a)) begin
      e.data = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  // Queue the B expectation and apply the write to the reference model.
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    logic [31:0] w;
    e.is_rd = 1'b0;
    e.data  = 32'h0;
    e.resp  = in_rng(a) ? 2'b00 : 2'b10;
    sb.push_back(e);
    if (in_rng(a)) begin
      w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model[widx(a)] = w;
    end
  endtask

  task automatic wait_lat(input string tag, input bit rd, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rd ? mem_rvalid : mem_bvalid) break;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit acc;
    push_wr(a, d, s);
    mem_awvalid = 1'b1; mem_awaddr = a;
    mem_wvalid  = 1'b1; mem_wdata  = d; mem_wstrb = {4'hA, s};
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_awready && mem_wready) begin acc = 1'b1; break; end
    end
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    @(posedge clk); #1;
    mem_awvalid = 1'b0; mem_wvalid = 1'b0;
    if (acc) wait_lat({tag, "_blat"}, 1'b0, WL);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    bit acc;
    sb.push_back(exp_rd(a));
    mem_arvalid = 1'b1; mem_araddr = a;
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_arready) begin acc = 1'b1; break; end
    end
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    @(posedge clk); #1;
    mem_arvalid = 1'b0;
    if (acc) wait_lat({tag, "_rlat"}, 1'b1, RL);
  endtask

  // Response monitor: a handshake completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mem_rvalid && mem_rready) begin
      n_rhs++;
      if (sb.size() == 0) chk("sb_empty_r", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("r_kind", 32'(e.is_rd), 32'd1);
        chk("r_data", mem_rdata, e.data);
        chk("r_resp", 32'(mem_rresp), 32'(e.resp));
      end
    end
    if (!rst && mem_bvalid && mem_bready) begin
      if (sb.size() == 0) chk("sb_empty_b", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("b_kind", 32'(e.is_rd), 32'd0);
        chk("b_resp", 32'(mem_bresp), 32'(e.resp));
      end
    end
  end

  initial begin
    int   rhs0;
    bit   acc;
    exp_t er;
    rst = 1'b1;
    mem_awvalid = 1'b0; mem_awaddr = '0; mem_wvalid = 1'b0; mem_wdata = '0; mem_wstrb = '0;
    mem_bready = 1'b1; mem_arvalid = 1'b0; mem_araddr = '0; mem_rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(mem_rvalid), 32'd0);
    chk("rst_bvalid", 32'(mem_bvalid), 32'd0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_rresp", 32'(mem_rresp), 32'd0);
    chk("rst_bresp", 32'(mem_bresp), 32'd0);
    chk("rst_arready", 32'(mem_arready), 32'd0);
    chk("rst_awready", 32'(mem_awready), 32'd0);
    chk("rst_wready", 32'(mem_wready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_arready", 32'(mem_arready), 32'd1);

    do_write("wr_basic", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    do_read("rd_basic", 32'h8000_0010);

    do_write("wr_pre", 32'h8000_0040, 32'h1122_3344, 4'hF);
    do_write("wr_strb", 32'h8000_0040, 32'hAABB_CCDD, 4'b0101);
    do_read("rd_strb", 32'h8000_0040);
    do_write("wr_strb0", 32'h8000_0040, 32'hFFFF_FFFF, 4'b0000);
    do_read("rd_strb0", 32'h8000_0040);

    do_write("wr_w0", 32'h8000_0000, 32'hCAFE_F00D, 4'hF);
    do_read("rd_below", 32'h7FFF_FFFC);
    do_read("rd_above", 32'h8000_1000);
    do_write("wr_above", 32'h8000_1000, 32'h1234_5678, 4'hF);
    do_read("rd_w0", 32'h8000_0000);
    do_read("rd_last", 32'h8000_0FFC + 32'h0);

    // Backpressure: R held for five cycles with rready low.
    do_write("wr_bp", 32'h8000_0080, 32'h0BAD_C0DE, 4'hF);
    mem_rready = 1'b0;
    do_read("rd_bp", 32'h8000_0080);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rvalid", 32'(mem_rvalid), 32'd1);
      chk("bp_rdata", mem_rdata, 32'h0BAD_C0DE);
      chk("bp_arready", 32'(mem_arready), 32'd0);
    end
    mem_rready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rvalid_drop", 32'(mem_rvalid), 32'd0);
    chk("bp_idle_arready", 32'(mem_arready), 32'd1);
    chk("bp_rdata_hold", mem_rdata, 32'h0BAD_C0DE);

    // Simultaneous AR and AW+W: read first with pre-write data.
    do_write("wr_sim_pre", 32'h8000_0100, 32'h5555_6666, 4'hF);
    er = exp_rd(32'h8000_0100);
    sb.push_back(er);
    push_wr(32'h8000_0100, 32'h7777_8888, 4'hF);
    rhs0 = n_rhs;
    mem_arvalid = 1'b1; mem_araddr = 32'h8000_0100;
    mem_awvalid = 1'b1; mem_awaddr = 32'h8000_0100;
    mem_wvalid  = 1'b1; mem_wdata  = 32'h7777_8888; mem_wstrb = 8'h0F;
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_arready) begin acc = 1'b1; break; end
    end
    chk("sim_ar_acc", 32'(acc), 32'd1);
    @(posedge clk); #1;
    mem_arvalid = 1'b0;
    wait_lat("sim_rlat", 1'b1, RL);
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_awready && mem_wready) begin acc = 1'b1; break; end
    end
    chk("sim_aw_acc", 32'(acc), 32'd1);
    chk("sim_rd_first", 32'(n_rhs), 32'(rhs0 + 1));
    @(posedge clk); #1;
    mem_awvalid = 1'b0; mem_wvalid = 1'b0;
    wait_lat("sim_blat", 1'b0, WL);
    do_read("rd_sim_post", 32'h8000_0100);

    // Reset during WR_WAIT abandons the write.
    do_write("wr_rst_pre", 32'h8000_0020, 32'hA1A2_A3A4, 4'hF);
    mem_awvalid = 1'b1; mem_awaddr = 32'h8000_0020;
    mem_wvalid  = 1'b1; mem_wdata  = 32'hFFFF_FFFF; mem_wstrb = 8'h0F;
    acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_awready) begin acc = 1'b1; break; end
    end
    chk("rstw_acc", 32'(acc), 32'd1);
    @(posedge clk); #1;
    mem_awvalid = 1'b0; mem_wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_bvalid", 32'(mem_bvalid), 32'd0);
    chk("rstw_rvalid", 32'(mem_rvalid), 32'd0);
    chk("rstw_arready_lo", 32'(mem_arready), 32'd0);
    @(posedge clk); #1;
    chk("rstw_arready_hi", 32'(mem_arready), 32'd1);
    chk("rstw_bvalid2", 32'(mem_bvalid), 32'd0);
    do_read("rd_rst_post", 32'h8000_0020);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
